hazard_control_unit: RTL
========================

// Module: hazard_control_unit
// PURPOSE
//  Pipeline hazard sequencer for the 5-stage MIPS core; sits beside the forwarding unit at ID.
//  Detects dependencies forwarding cannot cover (load-use, jump-register on a load result)
//  and runs the multi-cycle stall: freezes PC and IF/ID, injects bubbles into ID/EX.
//  Flushes IF/ID on a taken branch or jump resolved in ID.
// PARAMETERS
//  NB_REG_ADDR   5   register address width
//  NB_STALL_CNT  2   stall down-counter width (max stall length 3)
//  NB_STAT       32  width of statistics counters (HAZARD_STATS_EN only)
// PORTS
//  i_clock        in   1            clock
//  i_reset        in   1            synchronous, active-high reset
//  i_valid        in   1            pipeline advance enable (0 = debug freeze)
//  i_rs_id        in   NB_REG_ADDR  rs of instruction in ID
//  i_rt_id        in   NB_REG_ADDR  rt of instruction in ID
//  i_uses_rs      in   1            ID instruction reads rs
//  i_uses_rt      in   1            ID instruction reads rt (R-type, store, branch)
//  i_jump_rs      in   1            ID instruction is jr/jalr (rs consumed in ID)
//  i_branch_taken in   1            branch in ID resolved taken
//  i_jump_taken   in   1            j/jal/jr/jalr in ID
//  i_load_ex      in   1            instruction in EX is a load
//  i_we_ex        in   1            EX instruction writes a register
//  i_rd_ex        in   NB_REG_ADDR  EX destination register
//  i_load_mem     in   1            instruction in MEM is a load
//  i_rd_mem       in   NB_REG_ADDR  MEM destination register
//  o_stall_pc     out  1            hold PC
//  o_stall_ifid   out  1            hold IF/ID register
//  o_bubble_idex  out  1            load NOP into ID/EX
//  o_flush_ifid   out  1            replace IF/ID with NOP
//  o_busy         out  1            FSM in STALL state
// BEHAVIOUR
//  - Register 0 never creates a hazard. Match = (src == rd) & (rd != 0) & uses_src.
//  - Hazard table (registered stall length N, evaluated in RUN only):
//      jr/jalr rs matches load in EX                      -> N = 2
//      rs/rt matches load in EX (non-jump)                -> N = 1
//      jr/jalr rs matches load in MEM                     -> N = 1
//      jr/jalr rs matches ALU result in EX (i_we_ex)      -> N = 0 (forwarded)
//    Multiple matches: take the largest N.
//  - FSM states RUN, STALL; 2-bit counter cnt.
//    RUN:   N>0 -> stall outputs = 1 this cycle (combinational); cnt <= N-1;
//           go STALL if N-1 != 0, else stay RUN.
//    STALL: stall outputs = 1; cnt <= cnt-1; return to RUN when cnt reaches 1->0
//           (last stall cycle is the one with cnt == 1). No new detection in STALL.
//  - Stall outputs: o_stall_pc = o_stall_ifid = o_bubble_idex, always together.
//  - Flush: o_flush_ifid = (i_branch_taken | i_jump_taken) & ~stall, one cycle per event.
//    Stall beats flush: a stalled branch/jump flushes only on the cycle it leaves ID.
//  - i_valid = 0: state and cnt hold; all outputs forced 0; resume exactly where left.
//  - Reset (also mid-stall): state = RUN, cnt = 0; all outputs 0 during and after reset
//    until inputs create a hazard; statistics counters cleared.
//  - Zero-latency detection (comb from ID/EX inputs); sequential effect is cnt/state only.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds ports o_stall_cycles [NB_STAT] (+1 per cycle with stall
//    outputs high) and o_flush_count [NB_STAT] (+1 per o_flush_ifid pulse); both count only
//    when i_valid = 1, saturate at all-ones, clear on reset.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. lw $2 in EX, ID add $3,$2,$4 -> stall/bubble high exactly 1 cycle, o_busy stays 0.
//  2. lw $5 in EX, ID jr $5 -> stall 2 cycles, o_busy=1 on the 2nd, then RUN; no flush until jr leaves.
//  3. addi $5 in EX (we_ex=1, load_ex=0), ID jr $5 -> no stall, o_flush_ifid=1 one cycle.
//  4. lw $0 in EX, ID add $3,$0,$0 -> no stall; beq taken with no hazard -> flush 1 cycle.
//  5. jr $5 stalled (cycle 1 of 2), drop i_valid 3 cycles, restore -> exactly 1 more stall cycle.
//  6. Assert i_reset during STALL -> next cycle RUN, cnt=0, outputs 0; with HAZARD_STATS_EN
//     after test 2 o_stall_cycles=2, o_flush_count=1 once jr resolves.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - ID/EX/MEM hazard inputs and stall/flush controls of the hazard sequencer
// Optional statistics ports appear when HAZARD_STATS_EN is defined.
interface hazard_control_unit_if #(
  parameter int NB_REG_ADDR = 5
`ifdef HAZARD_STATS_EN
  , parameter int NB_STAT = 32
`endif
);

  logic                   i_valid;
  logic [NB_REG_ADDR-1:0] i_rs_id;
  logic [NB_REG_ADDR-1:0] i_rt_id;
  logic                   i_uses_rs;
  logic                   i_uses_rt;
  logic                   i_jump_rs;
  logic                   i_branch_taken;
  logic                   i_jump_taken;
  logic                   i_load_ex;
  logic                   i_we_ex;
  logic [NB_REG_ADDR-1:0] i_rd_ex;
  logic                   i_load_mem;
  logic [NB_REG_ADDR-1:0] i_rd_mem;

  logic                   o_stall_pc;
  logic                   o_stall_ifid;
  logic                   o_bubble_idex;
  logic                   o_flush_ifid;
  logic                   o_busy;
`ifdef HAZARD_STATS_EN
  logic [NB_STAT-1:0]     o_stall_cycles;
  logic [NB_STAT-1:0]     o_flush_count;
`endif

  modport master (
    output i_valid, i_rs_id, i_rt_id, i_uses_rs, i_uses_rt, i_jump_rs,
           i_branch_taken, i_jump_taken, i_load_ex, i_we_ex, i_rd_ex,
           i_load_mem, i_rd_mem,
    input  o_stall_pc, o_stall_ifid, o_bubble_idex, o_flush_ifid, o_busy
`ifdef HAZARD_STATS_EN
    , input o_stall_cycles, o_flush_count
`endif
  );

  modport slave (
    input  i_valid, i_rs_id, i_rt_id, i_uses_rs, i_uses_rt, i_jump_rs,
           i_branch_taken, i_jump_taken, i_load_ex, i_we_ex, i_rd_ex,
           i_load_mem, i_rd_mem,
    output o_stall_pc, o_stall_ifid, o_bubble_idex, o_flush_ifid, o_busy
`ifdef HAZARD_STATS_EN
    , output o_stall_cycles, o_flush_count
`endif
  );

endinterface

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use / jump-register stall sequencer and IF/ID flush control
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_control_unit #(
  parameter int NB_REG_ADDR  = 5,
  parameter int NB_STALL_CNT = 2
`ifdef HAZARD_STATS_EN
  , parameter int NB_STAT    = 32
`endif
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  hazard_control_unit_if.slave bus
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  localparam logic [NB_REG_ADDR-1:0]  REG_ZERO = '0;
  localparam logic [NB_STALL_CNT-1:0] LEN_0    = '0;
  localparam logic [NB_STALL_CNT-1:0] LEN_1    = NB_STALL_CNT'(1);
  localparam logic [NB_STALL_CNT-1:0] LEN_2    = NB_STALL_CNT'(2);

  logic [0:0]              state;
  logic [NB_STALL_CNT-1:0] cnt;
  logic [NB_STALL_CNT-1:0] stall_len;

  logic rs_hit_ex;
  logic rt_hit_ex;
  logic rs_hit_mem;
  logic load_use_ex;
  logic jr_load_ex;
  logic jr_load_mem;
  logic jr_alu_ex;
  logic active;
  logic stall;
  logic flush;

  // $0 is hard-wired, so a zero destination never produces a dependency.
  assign rs_hit_ex  = (bus.i_rs_id == bus.i_rd_ex)  && (bus.i_rd_ex  != REG_ZERO);
  assign rt_hit_ex  = (bus.i_rt_id == bus.i_rd_ex)  && (bus.i_rd_ex  != REG_ZERO);
  assign rs_hit_mem = (bus.i_rs_id == bus.i_rd_mem) && (bus.i_rd_mem != REG_ZERO);

  assign load_use_ex = bus.i_load_ex &
                       ((bus.i_uses_rs & rs_hit_ex) | (bus.i_uses_rt & rt_hit_ex));
  assign jr_load_ex  = bus.i_jump_rs & bus.i_load_ex  & rs_hit_ex;
  assign jr_load_mem = bus.i_jump_rs & bus.i_load_mem & rs_hit_mem;
  assign jr_alu_ex   = bus.i_jump_rs & bus.i_we_ex & ~bus.i_load_ex & rs_hit_ex;

  // Later assignments win, so the order below selects the longest required stall.
  always_comb begin
    stall_len = LEN_0;
    if (jr_alu_ex)   stall_len = LEN_0;
    if (load_use_ex) stall_len = LEN_1;
    if (jr_load_mem) stall_len = LEN_1;
    if (jr_load_ex)  stall_len = LEN_2;
  end

  assign active = bus.i_valid & ~i_reset;
  assign stall  = active & ((state == ST_STALL) ||
                            ((state == ST_RUN) && (stall_len != LEN_0)));
  assign flush  = active & (bus.i_branch_taken | bus.i_jump_taken) & ~stall;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= ST_RUN;
      cnt   <= LEN_0;
    end else if (bus.i_valid) begin
      if (state == ST_RUN) begin
        if (stall_len != LEN_0) begin
          cnt   <= stall_len - LEN_1;
          state <= (stall_len == LEN_1) ? ST_RUN : ST_STALL;
        end
      end else begin
        // The cycle with cnt == 1 is the final stall cycle.
        cnt <= cnt - LEN_1;
        if (cnt == LEN_1) state <= ST_RUN;
      end
    end
  end

  assign bus.o_stall_pc    = stall;
  assign bus.o_stall_ifid  = stall;
  assign bus.o_bubble_idex = stall;
  assign bus.o_flush_ifid  = flush;
  assign bus.o_busy        = active & (state == ST_STALL);

`ifdef HAZARD_STATS_EN
  localparam logic [NB_STAT-1:0] STAT_MAX = '1;
  localparam logic [NB_STAT-1:0] STAT_ONE = NB_STAT'(1);

  logic [NB_STAT-1:0] stall_cycles;
  logic [NB_STAT-1:0] flush_count;

  // stall and flush are already zero while frozen, so only valid cycles count.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall && (stall_cycles != STAT_MAX)) stall_cycles <= stall_cycles + STAT_ONE;
      if (flush && (flush_count  != STAT_MAX)) flush_count  <= flush_count  + STAT_ONE;
    end
  end

  assign bus.o_stall_cycles = stall_cycles;
  assign bus.o_flush_count  = flush_count;
`endif

endmodule
